// File: rtl/alu_sched_pkg.sv
// Shared op codes, constants and response record for the ALU command scheduler.
package alu_sched_pkg;

    localparam logic [3:0]  OP_ADD      = 4'd0;
    localparam logic [3:0]  OP_SUB      = 4'd1;
    localparam logic [3:0]  OP_MUL      = 4'd2;
    localparam logic [3:0]  OP_DIV      = 4'd3;
    localparam logic [15:0] ALU_DEFAULT = 16'h1507;
    localparam logic [15:0] DIV0_DATA   = 16'hFFFF;

    // The caller tag travels next to this record because its width is a module parameter.
    typedef struct packed {
        logic [15:0] data;
        logic        carry;
        logic        err;
    } rsp_t;

    function automatic logic is_div0(input logic [3:0] op, input logic [7:0] b);
        return (op == OP_DIV) && (b == 8'd0);
    endfunction

endpackage

// File: rtl/alu_sched_fifo.sv
// Generic synchronous FIFO with show-ahead read data; callers never push when full or pop when empty.
module alu_sched_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/alu_cmd_sched.sv
// Command scheduler in front of a 1-cycle registered 8-bit ALU, returning tagged responses in order.
// Optional ALU_SCHED_STATS_EN adds saturating stat_cmds / stat_errs counters.
module alu_cmd_sched
    import alu_sched_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [3:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_op_sel,
    input  logic [15:0]      alu_out,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_data,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag
`ifdef ALU_SCHED_STATS_EN
    ,
    output logic [15:0]      stat_cmds,
    output logic [15:0]      stat_errs
`endif
);

    localparam int CCW = $clog2(CMD_DEPTH) + 1;
    localparam int RCW = $clog2(RSP_DEPTH) + 1;
    localparam int UW  = RCW + 1;

    typedef struct packed {
        logic [7:0]       a;
        logic [7:0]       b;
        logic [3:0]       op;
        logic [TAG_W-1:0] tag;
        logic             div0;
    } cmd_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             op0;
        logic             div0;
    } stage_t;

    cmd_t             cmd_in;
    cmd_t             cmd_head;
    logic             cmd_push;
    logic             cmd_full;
    logic             cmd_empty;
    logic [CCW-1:0]   cmd_count;
    logic             issue;
    logic [UW-1:0]    used;
    stage_t           s1;
    stage_t           s2;
    rsp_t             rsp_in;
    rsp_t             rsp_out;
    logic             rsp_pop;
    logic             rsp_full;
    logic             rsp_empty;
    logic [RCW-1:0]   rsp_count;

    assign cmd_ready = rstn && !cmd_full;
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_in    = '{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag, div0: is_div0(cmd_op, cmd_b)};

    alu_sched_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (cmd_push),
        .wdata (cmd_in),
        .pop   (issue),
        .rdata (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    // Credit check: every queued or in-flight result is guaranteed a response slot.
    assign used  = UW'(rsp_count) + UW'(s1.valid) + UW'(s2.valid);
    assign issue = !cmd_empty && (used < UW'(RSP_DEPTH));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op_sel <= '0;
            s1         <= '0;
            s2         <= '0;
        end else begin
            if (issue) begin
                alu_a      <= cmd_head.a;
                alu_b      <= cmd_head.b;
                alu_op_sel <= cmd_head.op;
            end
            s1.valid <= issue;
            s1.tag   <= cmd_head.tag;
            s1.op0   <= (cmd_head.op == OP_ADD);
            s1.div0  <= cmd_head.div0;
            s2       <= s1;
        end
    end

    // Stage 2 lines up with the ALU result registered from the issue cycle.
    always_comb begin
        rsp_in       = '0;
        rsp_in.data  = s2.div0 ? DIV0_DATA : alu_out;
        rsp_in.carry = s2.op0 && alu_carry;
        rsp_in.err   = s2.div0;
    end

    assign rsp_valid = !rsp_empty;
    assign rsp_pop   = rsp_valid && rsp_ready;

    alu_sched_fifo #(.WIDTH($bits(rsp_t) + TAG_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (s2.valid),
        .wdata ({s2.tag, rsp_in}),
        .pop   (rsp_pop),
        .rdata ({rsp_tag, rsp_out}),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    assign rsp_data  = rsp_out.data;
    assign rsp_carry = rsp_out.carry;
    assign rsp_err   = rsp_out.err;

    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!(s2.valid && rsp_full && !rsp_pop));
            assert (cmd_count <= CCW'(CMD_DEPTH));
        end
    end

`ifdef ALU_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_cmds <= '0;
            stat_errs <= '0;
        end else begin
            if (cmd_push && stat_cmds != 16'hFFFF)          stat_cmds <= stat_cmds + 16'd1;
            if (rsp_pop && rsp_err && stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
        end
    end
`endif

endmodule
